// File: rtl/riscv_multicycle_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_multicycle_if
//  Description : Unified instruction/data memory port of the multicycle
//                RV32I-subset core. The core drives a byte address, a write
//                enable and store data. The memory returns read data for the
//                current address in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface riscv_multicycle_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  localparam int MLEN = (XLEN > ILEN) ? XLEN : ILEN;

  logic [XLEN-1:0] mem_addr_o;
  logic [MLEN-1:0] mem_rdata_i;
  logic            mem_we_o;
  logic [MLEN-1:0] mem_wdata_o;

  // Core side: drives address, write enable and store data
  modport master (
    output mem_addr_o,
    output mem_we_o,
    output mem_wdata_o,
    input  mem_rdata_i
  );

  // Memory side: returns combinational read data
  modport slave (
    input  mem_addr_o,
    input  mem_we_o,
    input  mem_wdata_o,
    output mem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/riscv_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_multicycle
//  Description : Multicycle RV32I-subset core (lw, sw, add, sub, and, or,
//                slt, addi, andi, ori, slti, beq, jal). It uses a single
//                unified memory port. Each instruction takes 2 to 5 cycles
//                through a FETCH/DECODE/execute control FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_multicycle #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  riscv_multicycle_if.master  mem
);

  localparam int MLEN = (XLEN > ILEN) ? XLEN : ILEN;

  // Opcodes of the supported instruction classes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU funct3 selectors shared by R-type and I-type
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LSW = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // FETCH must be encoding 0 so that reset lands there
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t state_q;
  state_t state_d;

  // Architectural and intermediate registers
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] oldpc_q;
  logic [ILEN-1:0] ir_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] aluout_q;
  logic [XLEN-1:0] rf [32];

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  // Sign-extended immediates (I, S, B, J formats)
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;

  assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                  ir_q[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20],
                  ir_q[30:21], 1'b0};

  // Instruction class decode; anything not matched retires as a NOP
  logic alu_f3_ok;
  logic is_lw;
  logic is_sw;
  logic is_r;
  logic is_i;
  logic is_beq;
  logic is_jal;

  assign alu_f3_ok = (funct3 == F3_ADD) || (funct3 == F3_SLT) ||
                     (funct3 == F3_OR)  || (funct3 == F3_AND);
  assign is_lw  = (opcode == OP_LOAD)  && (funct3 == F3_LSW);
  assign is_sw  = (opcode == OP_STORE) && (funct3 == F3_LSW);
  assign is_r   = (opcode == OP_REG) &&
                  (((funct7 == F7_BASE) && alu_f3_ok) ||
                   ((funct7 == F7_SUB)  && (funct3 == F3_ADD)));
  assign is_i   = (opcode == OP_IMM) && alu_f3_ok;
  assign is_beq = (opcode == OP_BRANCH) && (funct3 == F3_BEQ);
  assign is_jal = (opcode == OP_JAL);

  // ALU: second operand is b_q for R-type, immI for I-type
  logic [XLEN-1:0] alu_b;
  logic            alu_sub;
  logic [XLEN-1:0] alu_res;

  // Combinational ALU selected by funct3 (and funct7 for sub)
  always_comb begin
    alu_b   = (state_q == EXECR) ? b_q : imm_i;
    alu_sub = (state_q == EXECR) && (funct7 == F7_SUB);
    alu_res = '0;
    case (funct3)
      F3_ADD:  alu_res = alu_sub ? (a_q - alu_b) : (a_q + alu_b);
      F3_AND:  alu_res = a_q & alu_b;
      F3_OR:   alu_res = a_q | alu_b;
      F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
      default: alu_res = '0;
    endcase
  end

  // Control FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  logic [XLEN-1:0] addr_c;
  logic            we_c;
  logic [MLEN-1:0] wdata_c;

  // Next-state logic and memory-port outputs; reset forces a quiet bus
  always_comb begin
    state_d = state_q;
    addr_c  = pc_q;
    we_c    = 1'b0;
    wdata_c = MLEN'(b_q);
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        if (is_lw || is_sw)  state_d = MEMADR;
        else if (is_r)       state_d = EXECR;
        else if (is_i)       state_d = EXECI;
        else if (is_beq)     state_d = BEQ;
        else if (is_jal)     state_d = JAL;
        else                 state_d = FETCH;
      end
      MEMADR:   state_d = is_sw ? MEMWRITE : MEMREAD;
      MEMREAD: begin
        addr_c  = aluout_q;
        state_d = MEMWB;
      end
      MEMWB:    state_d = FETCH;
      MEMWRITE: begin
        addr_c  = aluout_q;
        we_c    = 1'b1;
        state_d = FETCH;
      end
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
    // An in-flight store is abandoned as soon as reset is seen
    if (rst_i) begin
      addr_c  = '0;
      we_c    = 1'b0;
      wdata_c = '0;
    end
  end

  assign mem.mem_addr_o  = addr_c;
  assign mem.mem_we_o    = we_c;
  assign mem.mem_wdata_o = wdata_c;

  // Datapath registers updated according to the current control state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= '0;
      oldpc_q  <= '0;
      ir_q     <= '0;
      data_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          ir_q    <= mem.mem_rdata_i[ILEN-1:0];
          oldpc_q <= pc_q;
          pc_q    <= pc_q + XLEN'(4);
        end
        DECODE: begin
          a_q      <= rf[rs1];
          b_q      <= rf[rs2];
          // Branch target precomputed here for use by BEQ
          aluout_q <= oldpc_q + imm_b;
        end
        MEMADR:  aluout_q <= a_q + (is_sw ? imm_s : imm_i);
        MEMREAD: data_q   <= mem.mem_rdata_i[XLEN-1:0];
        EXECR:   aluout_q <= alu_res;
        EXECI:   aluout_q <= alu_res;
        BEQ: begin
          if (a_q == b_q) begin
            pc_q <= aluout_q;
          end
        end
        JAL: begin
          pc_q     <= oldpc_q + imm_j;
          // pc_q already holds oldpc+4, the return address
          aluout_q <= pc_q;
        end
        default: ;
      endcase
    end
  end

  // Register file write port; x0 is never written so it always reads 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (((state_q == MEMWB) || (state_q == ALUWB)) && (rd != 5'd0)) begin
      rf[rd] <= (state_q == MEMWB) ? data_q : aluout_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_multicycle
//  Description : Self-checking bench for riscv_multicycle. It models a
//                256-word RAM, runs short programs, scoreboards every store
//                seen on the bus and checks architectural state.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_multicycle;

  logic clk;
  logic rst;
  logic load_req;

  riscv_multicycle_if #(.XLEN(32), .ILEN(32)) bus ();

  riscv_multicycle #(.XLEN(32), .ILEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .mem   (bus)
  );

  logic [31:0] ram  [256];
  logic [31:0] prog [256];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } store_t;

  store_t exp_q [$];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed RAM: byte address bits [1:0] ignored, combinational read
  assign bus.mem_rdata_i = ram[bus.mem_addr_o[9:2]];

  // RAM write port; also copies the staged program image on request
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) ram[i] <= prog[i];
    end else if (bus.mem_we_o) begin
      ram[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: scoreboard the bus at the falling edge, then advance
  task automatic step();
    store_t e;
    @(negedge clk);
    if (bus.mem_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_store", bus.mem_addr_o, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("store_addr", bus.mem_addr_o, e.addr);
        check("store_data", bus.mem_wdata_o, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  task automatic load_and_reset();
    rst      = 1'b1;
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_until(input logic [31:0] end_pc, input int bound);
    int n = 0;
    while (!((dut.pc_q == end_pc) && (32'(dut.state_q) == 32'd0)) && (n < bound)) begin
      step();
      n++;
    end
    check("run_done", 32'(n < bound), 32'd1);
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  int          pw;
  logic [31:0] va;
  logic [31:0] vb;
  logic [31:0] acc;
  logic [11:0] off;

  task automatic emit(input logic [31:0] w);
    prog[pw] = w;
    pw++;
  endtask

  // Store x3 to a fresh slot and expect the given value on the bus
  task automatic emit_store_x3(input logic [31:0] expv);
    store_t e;
    emit(enc_s(off, 5'd3, 5'd0));
    e.addr = {20'h0, off};
    e.data = expv;
    exp_q.push_back(e);
    off = off + 12'd4;
  endtask

  initial begin
    rst      = 1'b1;
    load_req = 1'b0;
    clear_prog();

    // Reset state, then addi x1,x0,5
    prog[0] = 32'h0050_0093;
    load_and_reset();
    check("rst_pc", dut.pc_q, 32'h0);
    check("rst_state", 32'(dut.state_q), 32'd0);
    check("rst_we", 32'(bus.mem_we_o), 32'd0);
    check("rst_addr", bus.mem_addr_o, 32'h0);
    check("rst_wdata", bus.mem_wdata_o, 32'h0);
    repeat (4) step();
    check("addi_x1", dut.rf[1], 32'd5);
    check("addi_pc", dut.pc_q, 32'd4);
    check("addi_state", 32'(dut.state_q), 32'd0);

    // addi; sw x1,64(x0); lw x2,64(x0)
    clear_prog();
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0410_2023;
    prog[2] = 32'h0400_2103;
    exp_q.push_back('{addr: 32'h40, data: 32'd5});
    load_and_reset();
    repeat (13) step();
    check("lw_x2", dut.rf[2], 32'd5);
    check("lw_pc", dut.pc_q, 32'd12);
    check("sw_ram", ram[16], 32'd5);
    check("sb_drain_1", 32'(exp_q.size()), 32'd0);

    // beq x0,x0,+8 taken
    clear_prog();
    prog[0] = 32'h0000_0463;
    load_and_reset();
    repeat (3) step();
    check("beq_taken_pc", dut.pc_q, 32'd8);

    // addi x1,x0,5; beq x1,x0,+8 at 4 not taken
    clear_prog();
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0000_8463;
    load_and_reset();
    repeat (7) step();
    check("beq_nt_pc", dut.pc_q, 32'd8);
    check("beq_nt_state", 32'(dut.state_q), 32'd0);

    // jal x1,+8
    clear_prog();
    prog[0] = 32'h0080_00EF;
    load_and_reset();
    repeat (4) step();
    check("jal_pc", dut.pc_q, 32'd8);
    check("jal_x1", dut.rf[1], 32'd4);

    // addi x0,x0,7 discarded
    clear_prog();
    prog[0] = 32'h0070_0013;
    load_and_reset();
    repeat (4) step();
    check("x0_zero", dut.rf[0], 32'd0);
    check("x0_pc", dut.pc_q, 32'd4);

    // Unsupported opcode retires in 2 cycles
    clear_prog();
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0000_007F;
    load_and_reset();
    repeat (6) step();
    check("unsup_pc", dut.pc_q, 32'd8);
    check("unsup_state", 32'(dut.state_q), 32'd0);
    check("unsup_x1", dut.rf[1], 32'd5);

    // ALU program: results stored and scoreboarded on the bus
    clear_prog();
    pw  = 0;
    off = 12'h100;
    va  = 32'hFFFF_FFFD;
    vb  = 32'd5;
    emit(enc_i(12'hFFD, 5'd0, 3'b000, 5'd1));
    emit(enc_i(12'h005, 5'd0, 3'b000, 5'd2));
    emit(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3)); emit_store_x3(va + vb);
    emit(enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd3)); emit_store_x3(va + vb);
    emit(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3)); emit_store_x3(va - vb);
    emit(enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3)); emit_store_x3(va & vb);
    emit(enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3)); emit_store_x3(va | vb);
    emit(enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3)); emit_store_x3(32'd1);
    emit(enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd3)); emit_store_x3(32'd0);
    emit(enc_i(12'hFFB, 5'd1, 3'b010, 5'd3));     emit_store_x3(32'd0);
    emit(enc_i(12'h0F0, 5'd1, 3'b111, 5'd3));     emit_store_x3(va & 32'h0000_00F0);
    emit(enc_i(12'hFF0, 5'd2, 3'b110, 5'd3));     emit_store_x3(vb | 32'hFFFF_FFF0);
    emit(enc_i(12'h004, 5'd1, 3'b000, 5'd3));     emit_store_x3(va + 32'd4);
    load_and_reset();
    run_until(32'(pw * 4), 400);
    check("sb_drain_alu", 32'(exp_q.size()), 32'd0);
    check("alu_x1", dut.rf[1], va);

    // Reset asserted during the MEMWRITE cycle of sw
    clear_prog();
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0410_2023;
    load_and_reset();
    repeat (7) step();
    check("mw_we", 32'(bus.mem_we_o), 32'd1);
    check("mw_addr", bus.mem_addr_o, 32'h40);
    rst = 1'b1;
    #1;
    check("rst_mw_we", 32'(bus.mem_we_o), 32'd0);
    check("rst_mw_addr", bus.mem_addr_o, 32'h0);
    check("rst_mw_wdata", bus.mem_wdata_o, 32'h0);
    step();
    check("rst_mw_pc", dut.pc_q, 32'h0);
    check("rst_mw_state", 32'(dut.state_q), 32'd0);
    acc = dut.oldpc_q | dut.ir_q | dut.data_q | dut.a_q | dut.b_q | dut.aluout_q;
    for (int i = 0; i < 32; i++) acc = acc | dut.rf[i];
    check("rst_mw_regs", acc, 32'h0);
    check("rst_mw_ram", ram[16], 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_we", 32'(bus.mem_we_o), 32'd0);
    step();
    check("post_rst_ram", ram[16], 32'h0);
    check("sb_drain_end", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
